when_case_decoder: RTL and testbench

- Receive end of the select-priority encoding interface. An upstream encoder maps {sel1, sel2} priority selects onto 4-bit codes, and this block recovers the select pair from those codes.
- Two code tables exist:
  - Table A (combinational-path codes): 4'h5, 4'hF, 4'h2.
  - Table B (registered-path codes): 4'h3, 4'hD, 4'h4.
- Decoded pairs are buffered in a small FIFO behind a valid/ready handshake.
- Illegal codes are dropped and counted.

---
 rtl/when_case_decoder.sv | 114 +++++++++++
 tb/tb_when_case_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/when_case_decoder.sv
// when_case_decoder: recovers {sel1, sel2} select pairs from 4-bit priority
// codes, queues legal results in a small FIFO behind a valid/ready handshake,
// and drops and counts illegal codes.
module when_case_decoder #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             code_valid,
   output logic             code_ready,
   input  logic [3:0]       code,
   input  logic             code_kind,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic             sel1,
   output logic             sel2,
   output logic             err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occupancy;

   logic          legal;
   logic [1:0]    pair;
   logic          accept;
   logic          push;
   logic          pop;

   assign code_ready = (occupancy < (AW+1)'(DEPTH));
   assign dec_valid  = (occupancy != '0);
   assign accept     = code_valid && code_ready;
   assign push       = accept && legal;
   assign pop        = dec_valid && dec_ready;

   // Outputs are forced to 0 while empty, so stale slot contents never leak.
   assign sel1 = dec_valid ? mem[rd_ptr][1] : 1'b0;
   assign sel2 = dec_valid ? mem[rd_ptr][0] : 1'b0;

   // Decode the code against the table chosen by code_kind.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      legal = 1'b0;
      pair  = 2'b00;
      if (!code_kind) begin
         case (code)
            4'h5:    begin legal = 1'b1; pair = 2'b10; end
            4'hF:    begin legal = 1'b1; pair = 2'b01; end
            4'h2:    begin legal = 1'b1; pair = 2'b00; end
            default: begin legal = 1'b0; pair = 2'b00; end
         endcase
      end else begin
         case (code)
            4'h3:    begin legal = 1'b1; pair = 2'b10; end
            4'hD:    begin legal = 1'b1; pair = 2'b01; end
            4'h4:    begin legal = 1'b1; pair = 2'b00; end
            default: begin legal = 1'b0; pair = 2'b00; end
         endcase
      end
   end

   // Storage array: written on push only.
   // NOTE: the data array has no reset; validity is tracked by occupancy alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pair;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Error pulse and saturating illegal-code counter; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= accept && !legal;
         if (err_clr) begin
            err_count <= '0;
         end else if (accept && !legal && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_when_case_decoder.sv
// Directed testbench for when_case_decoder (DEPTH=2, CNT_W=2 so saturation
// is reachable in a few codes). Expected values are hand-computed.
module tb_when_case_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       code_valid;
   logic       code_ready;
   logic [3:0] code;
   logic       code_kind;
   logic       dec_valid;
   logic       dec_ready;
   logic       sel1;
   logic       sel2;
   logic       err;
   logic       err_clr;
   logic [1:0] err_count;

   int vectors = 0;
   int miscompares = 0;

   when_case_decoder #(.DEPTH(2), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code       (code),
      .code_kind  (code_kind),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .sel1       (sel1),
      .sel2       (sel2),
      .err        (err),
      .err_clr    (err_clr),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Check every output: ready, valid, {sel1,sel2}, err, err_count.
   task automatic check_all(input string tag, input logic rdy, input logic vld,
                            input logic [1:0] sel, input logic e, input logic [1:0] cnt);
      check({tag, ".code_ready"}, {7'd0, code_ready}, {7'd0, rdy});
      check({tag, ".dec_valid"},  {7'd0, dec_valid},  {7'd0, vld});
      check({tag, ".sel"},        {6'd0, sel1, sel2}, {6'd0, sel});
      check({tag, ".err"},        {7'd0, err},        {7'd0, e});
      check({tag, ".err_count"},  {6'd0, err_count},  {6'd0, cnt});
   endtask

   // Advance one clock edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; code_valid = 1'b0; code = 4'h0; code_kind = 1'b0;
      dec_ready = 1'b0; err_clr = 1'b0;
      #12;
      check_all("reset", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
      rst_n = 1'b1;
      step();
      check_all("post_reset", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);

      // Table A stream with dec_ready=1
      dec_ready = 1'b1; code_valid = 1'b1; code_kind = 1'b0;
      code = 4'h5; step(); check_all("a5", 1'b1, 1'b1, 2'b10, 1'b0, 2'd0);
      code = 4'hF; step(); check_all("aF", 1'b1, 1'b1, 2'b01, 1'b0, 2'd0);
      code = 4'h2; step(); check_all("a2", 1'b1, 1'b1, 2'b00, 1'b0, 2'd0);
      code_valid = 1'b0; step(); check_all("a_drain", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);

      // Table B stream, then a Table A code flagged as Table B
      code_valid = 1'b1; code_kind = 1'b1;
      code = 4'h3; step(); check_all("b3", 1'b1, 1'b1, 2'b10, 1'b0, 2'd0);
      code = 4'hD; step(); check_all("bD", 1'b1, 1'b1, 2'b01, 1'b0, 2'd0);
      code = 4'h4; step(); check_all("b4", 1'b1, 1'b1, 2'b00, 1'b0, 2'd0);
      code = 4'h5; step(); check_all("b_illegal5", 1'b1, 1'b0, 2'b00, 1'b1, 2'd1);
      code_valid = 1'b0; step(); check_all("err_oneshot", 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);

      // Backpressure: fill FIFO, third code must stall
      dec_ready = 1'b0; code_valid = 1'b1; code_kind = 1'b0;
      code = 4'h5; step(); check_all("bp1", 1'b1, 1'b1, 2'b10, 1'b0, 2'd1);
      code = 4'hF; step(); check_all("bp2_full", 1'b0, 1'b1, 2'b10, 1'b0, 2'd1);
      code = 4'h2; step(); check_all("bp3_stall", 1'b0, 1'b1, 2'b10, 1'b0, 2'd1);
      code_valid = 1'b0; dec_ready = 1'b1;
      step(); check_all("bp_drain1", 1'b1, 1'b1, 2'b01, 1'b0, 2'd1);
      step(); check_all("bp_drain2", 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);

      // Full with dec_ready=1: no accept, then simultaneous push/pop
      dec_ready = 1'b0; code_valid = 1'b1; code_kind = 1'b1;
      code = 4'h3; step();
      code = 4'hD; step(); check_all("full", 1'b0, 1'b1, 2'b10, 1'b0, 2'd1);
      dec_ready = 1'b1; code = 4'h4;
      step(); check_all("full_pop_only", 1'b1, 1'b1, 2'b01, 1'b0, 2'd1);
      step(); check_all("push_pop", 1'b1, 1'b1, 2'b00, 1'b0, 2'd1);
      code_valid = 1'b0;
      step(); check_all("push_pop_drain", 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);

      // Saturating counter, then clear coinciding with an illegal accept
      err_clr = 1'b1; step(); check_all("clr_idle", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
      err_clr = 1'b0; code_valid = 1'b1; code_kind = 1'b0; code = 4'h3;
      step(); check_all("sat1", 1'b1, 1'b0, 2'b00, 1'b1, 2'd1);
      code = 4'h0; step(); check_all("sat2", 1'b1, 1'b0, 2'b00, 1'b1, 2'd2);
      code = 4'hD; step(); check_all("sat3", 1'b1, 1'b0, 2'b00, 1'b1, 2'd3);
      code = 4'hE; step(); check_all("sat4", 1'b1, 1'b0, 2'b00, 1'b1, 2'd3);
      code = 4'h4; step(); check_all("sat5", 1'b1, 1'b0, 2'b00, 1'b1, 2'd3);
      err_clr = 1'b1; code = 4'h1;
      step(); check_all("clr_wins", 1'b1, 1'b0, 2'b00, 1'b1, 2'd0);
      err_clr = 1'b0; code_valid = 1'b0;
      step(); check_all("clr_after", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);

      // Asynchronous reset with two entries buffered
      dec_ready = 1'b0; code_valid = 1'b1; code = 4'h5; step();
      code = 4'hF; step(); check_all("pre_rst_full", 1'b0, 1'b1, 2'b10, 1'b0, 2'd0);
      code_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all("async_rst", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
      @(negedge clk); rst_n = 1'b1;
      step(); check_all("post_async_rst", 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
